fsk_symbol_scheduler: RTL and testbench

FSK_SYMBOL_SCHEDULER -- requirements
Module: fsk_symbol_scheduler

---
 rtl/fsk_pkg.sv | 20 ++
 rtl/fsk_symbol_timer.sv | 35 +++
 rtl/fsk_symbol_scheduler.sv | 146 ++++++++++++++
 tb/tb_fsk_symbol_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// Shared FSK scheduler types: frame state enum and default phase steps.
// Macro FSK_SCHED_PARITY_EN adds the PARITY state (even parity symbol).
package fsk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    START,
    DATA,
`ifdef FSK_SCHED_PARITY_EN
    PARITY,
`endif
    STOP
  } fsk_state_e;

  localparam logic [4:0] STEP_MARK_DEF  = 5'd10;
  localparam logic [4:0] STEP_SPACE_DEF = 5'd5;
  localparam logic [4:0] STEP_IDLE_DEF  = 5'd1;

endpackage

// File: rtl/fsk_symbol_timer.sv
// Symbol-sample counter: runs 0..SYMBOL_SAMPLES-1 and wraps on its own.
// tc flags the last sample of a symbol; pre_tc flags that the next
// cycle will be the last sample (used to register a last-cycle output).
module fsk_symbol_timer #(
  parameter int unsigned SYMBOL_SAMPLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tc,
  output logic pre_tc
);

  localparam int unsigned CW = $clog2(SYMBOL_SAMPLES);
  localparam logic [CW-1:0] LAST = CW'(SYMBOL_SAMPLES - 1);
  localparam logic [CW-1:0] PRE  = CW'(SYMBOL_SAMPLES - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc     = (cnt_q == LAST);
  assign pre_tc = !clear && (cnt_q == PRE);

  // next count: clear to 0, wrap at terminal count, else increment
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tc) cnt_d = '0;
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fsk_symbol_scheduler.sv
// FSK symbol scheduler: frames a payload byte as preamble, start, 8 data
// bits LSB first, optional parity, stop; emits one phase step per cycle.
// Macro FSK_SCHED_PARITY_EN inserts an even-parity symbol before STOP.
// All outputs are registered and derived from the next state.
module fsk_symbol_scheduler
  import fsk_pkg::*;
#(
  parameter int unsigned SYMBOL_SAMPLES = 1000,
  parameter int unsigned PREAMBLE_BITS  = 16,
  parameter logic [4:0]  STEP_MARK      = STEP_MARK_DEF,
  parameter logic [4:0]  STEP_SPACE     = STEP_SPACE_DEF,
  parameter logic [4:0]  STEP_IDLE      = STEP_IDLE_DEF
) (
  input  logic       clk100mhz,
  input  logic       rst,
  input  logic [7:0] is8_data,
  input  logic       i_data_valid,
  output logic       o_data_ready,
  output logic [4:0] o5_step,
  output logic       o_bit,
  output logic       o_symbol_strobe,
  output logic       o_busy
);

  localparam logic [7:0] PRE_LAST = (PREAMBLE_BITS == 0) ? 8'd0 : 8'(PREAMBLE_BITS - 1);

  fsk_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       bit_q, bit_d;
  logic [4:0] step_q, step_d;
  logic       strobe_q, strobe_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;
  logic       accept, tc, pre_tc, tmr_clear;

  assign accept    = i_data_valid && ready_q;
  assign tmr_clear = (state_q == IDLE) || accept;

  fsk_symbol_timer #(.SYMBOL_SAMPLES(SYMBOL_SAMPLES)) u_timer (
    .clk    (clk100mhz),
    .rst    (rst),
    .clear  (tmr_clear),
    .tc     (tc),
    .pre_tc (pre_tc)
  );

  // next-state, symbol index and byte capture
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (accept) begin
        data_d  = is8_data;
        idx_d   = '0;
        state_d = (PREAMBLE_BITS == 0) ? START : PREAMBLE;
      end
      PREAMBLE: if (tc) begin
        if (idx_q == PRE_LAST) begin
          state_d = START;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      START: if (tc) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (tc) begin
        if (idx_q == 8'd7) begin
`ifdef FSK_SCHED_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
`ifdef FSK_SCHED_PARITY_EN
      PARITY: if (tc) state_d = STOP;
`endif
      STOP: begin
        // ready is only high on the last STOP cycle, so accept implies tc
        if (accept) begin
          data_d  = is8_data;
          idx_d   = '0;
          state_d = START;
        end else if (tc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // output values for the cycle after this edge
  always_comb begin
    bit_d = 1'b1;
    case (state_d)
      PREAMBLE: bit_d = ~idx_d[0];
      START:    bit_d = 1'b0;
      DATA:     bit_d = data_d[idx_d[2:0]];
`ifdef FSK_SCHED_PARITY_EN
      PARITY:   bit_d = ^data_d;
`endif
      default:  bit_d = 1'b1;
    endcase
    busy_d   = (state_d != IDLE);
    step_d   = !busy_d ? STEP_IDLE : (bit_d ? STEP_MARK : STEP_SPACE);
    strobe_d = accept || ((state_q != IDLE) && tc && busy_d);
    ready_d  = (state_d == IDLE) || ((state_d == STOP) && pre_tc);
  end

  // state and output registers, synchronous reset aborts any frame
  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      data_q   <= '0;
      bit_q    <= 1'b1;
      step_q   <= STEP_IDLE;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      bit_q    <= bit_d;
      step_q   <= step_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign o_data_ready    = ready_q;
  assign o5_step         = step_q;
  assign o_bit           = bit_q;
  assign o_symbol_strobe = strobe_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_fsk_symbol_scheduler.sv
// Bench for fsk_symbol_scheduler: directed frames plus random traffic,
// compared every cycle against a symbol-queue reference model.
module tb_fsk_symbol_scheduler;

  localparam int N  = 4;
  localparam int PB = 2;
  localparam logic [4:0] SM = 5'd10;
  localparam logic [4:0] SS = 5'd5;
  localparam logic [4:0] SI = 5'd1;
`ifdef FSK_SCHED_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk100mhz = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] is8_data = 8'h00;
  logic       i_data_valid = 1'b0;
  logic       o_data_ready, o_bit, o_symbol_strobe, o_busy;
  logic [4:0] o5_step;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int busy_cycles = 0;
  bit sym_bits[$];

  fsk_symbol_scheduler #(
    .SYMBOL_SAMPLES(N),
    .PREAMBLE_BITS (PB)
  ) dut (
    .clk100mhz      (clk100mhz),
    .rst            (rst),
    .is8_data       (is8_data),
    .i_data_valid   (i_data_valid),
    .o_data_ready   (o_data_ready),
    .o5_step        (o5_step),
    .o_bit          (o_bit),
    .o_symbol_strobe(o_symbol_strobe),
    .o_busy         (o_busy)
  );

  always #5 clk100mhz = ~clk100mhz;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // reference model: a frame is a queue of symbol bits, each held N cycles
  bit         q[$];
  int         cyc = 0;
  bit         m_accept = 0;
  logic       m_bit = 1'b1, m_strobe = 1'b0, m_busy = 1'b0, m_ready = 1'b0;
  logic [4:0] m_step = SI;

  always @(posedge clk100mhz) begin : model
    bit was_idle;
    if (rst) begin
      q.delete();
      cyc      = 0;
      m_accept = 0;
      m_ready  = 1'b0;
      m_strobe = 1'b0;
    end else begin
      m_accept = i_data_valid && m_ready;
      was_idle = (q.size() == 0);
      m_strobe = 1'b0;
      if (!was_idle) begin
        cyc++;
        if (cyc == N) begin
          void'(q.pop_front());
          cyc = 0;
          if (q.size() != 0) m_strobe = 1'b1;
        end
      end
      if (m_accept) begin
        if (was_idle) for (int i = 0; i < PB; i++) q.push_back(i % 2 == 0);
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(is8_data[i]);
        if (PAR != 0) q.push_back(^is8_data);
        q.push_back(1'b1);
        cyc      = 0;
        m_strobe = 1'b1;
      end
      m_ready = (q.size() == 0) || (q.size() == 1 && cyc == N - 1);
    end
    m_busy = (q.size() != 0);
    m_bit  = m_busy ? q[0] : 1'b1;
    m_step = !m_busy ? SI : (m_bit ? SM : SS);
  end

  // per-cycle comparison away from the active edge
  always @(negedge clk100mhz) begin
    chk("bit",    32'(o_bit),           32'(m_bit));
    chk("step",   32'(o5_step),         32'(m_step));
    chk("strobe", 32'(o_symbol_strobe), 32'(m_strobe));
    chk("busy",   32'(o_busy),          32'(m_busy));
    chk("ready",  32'(o_data_ready),    32'(m_ready));
    if (o_symbol_strobe) begin
      strobes++;
      sym_bits.push_back(o_bit);
    end
    if (o_busy) busy_cycles++;
  end

  task automatic tick();
    @(posedge clk100mhz);
    #1;
  endtask

  task automatic clr_stats();
    strobes = 0;
    busy_cycles = 0;
    sym_bits.delete();
  endtask

  task automatic wait_accept(input string tag);
    bit got;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      got = m_accept;
    end
    if (!got) chk(tag, 0, 1);
  endtask

  task automatic send(input logic [7:0] b);
    i_data_valid = 1'b1;
    is8_data     = b;
    wait_accept("accept_timeout");
    i_data_valid = 1'b0;
    is8_data     = 8'($urandom);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (!o_busy) done = 1;
    end
    if (!done) chk("idle_timeout", 0, 1);
    tick();
  endtask

  initial begin
    bit          exp_q[$];
    int          gap;
    logic [7:0]  pb;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_step",  32'(o5_step),         32'(SI));
    chk("rst_bit",   32'(o_bit),           32'(1));
    chk("rst_ready", 32'(o_data_ready),    32'(0));
    chk("rst_busy",  32'(o_busy),          32'(0));
    chk("rst_strb",  32'(o_symbol_strobe), 32'(0));

    // quiet period: no symbols, idle step, ready up
    rst = 1'b0;
    clr_stats();
    repeat (20) tick();
    chk("quiet_strobes", strobes, 0);
    chk("quiet_step",    32'(o5_step),      32'(SI));
    chk("quiet_ready",   32'(o_data_ready), 32'(1));

    // single byte A5
    clr_stats();
    send(8'hA5);
    wait_idle();
    exp_q = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1};
    if (PAR != 0) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    chk("a5_nsym",   strobes,     PB + 10 + PAR);
    chk("a5_cycles", busy_cycles, (PB + 10 + PAR) * N);
    for (int i = 0; i < exp_q.size() && i < sym_bits.size(); i++)
      chk("a5_sym", 32'(sym_bits[i]), 32'(exp_q[i]));
    chk("a5_step_end", 32'(o5_step), 32'(SI));

    // back-to-back: valid held, 00 then FF
    clr_stats();
    i_data_valid = 1'b1;
    is8_data     = 8'h00;
    wait_accept("b2b_first");
    is8_data = 8'hFF;
    gap = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      gap++;
      if (m_accept) break;
    end
    i_data_valid = 1'b0;
    chk("b2b_gap", gap, (PB + 10 + PAR) * N);
    wait_idle();
    chk("b2b_nsym", strobes, PB + 2 * (10 + PAR));
    if (sym_bits.size() > PB + 11 + PAR)
      chk("b2b_no_preamble", 32'(sym_bits[PB + 10 + PAR]), 32'(0));

    // parity symbol position: parity bit in the parity build, STOP otherwise
    for (int k = 0; k < 2; k++) begin
      pb = (k == 0) ? 8'h07 : 8'h03;
      repeat (3) tick();
      clr_stats();
      send(pb);
      wait_idle();
      chk("par_nsym", strobes, PB + 10 + PAR);
      if (sym_bits.size() > PB + 9)
        chk("par_sym", 32'(sym_bits[PB + 9]), (PAR != 0) ? 32'(^pb) : 32'(1));
    end

    // reset in the third data symbol
    repeat (2) tick();
    send(8'h5A);
    repeat ((PB + 1 + 2) * N + 1) tick();
    chk("mid_in_data", 32'(o_busy), 32'(1));
    rst = 1'b1;
    tick();
    chk("mid_step", 32'(o5_step), 32'(SI));
    chk("mid_busy", 32'(o_busy),  32'(0));
    rst = 1'b0;
    clr_stats();
    tick();
    chk("mid_ready", 32'(o_data_ready), 32'(1));
    repeat (12) tick();
    chk("mid_residual", strobes, 0);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      i_data_valid = ($urandom_range(0, 3) == 0);
      is8_data     = 8'($urandom);
      rst          = ($urandom_range(0, 699) == 0);
      tick();
    end
    rst = 1'b0;
    i_data_valid = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
